aexm_iqueue: RTL and testbench

AEXM_IQUEUE -- requirements
Module: aexm_iqueue

---
 rtl/aexm_pkg.sv | 43 ++++
 rtl/aexm_iqueue_fifo.sv | 49 ++++
 rtl/aexm_iqueue.sv | 129 ++++++++++++
 tb/tb_aexm_iqueue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aexm_pkg.sv
// Shared AEXM constants: opcode values, fixed instruction words and
// elaboration-time parameter range checks.
package aexm_pkg;

    localparam logic [31:0] NOP_WORD = 32'h88000000;
    localparam logic [31:0] INT_WORD = 32'hB9CE0010;

    localparam logic [5:0] OPC_IMM  = 6'o54;
    localparam logic [5:0] OPC_RTD  = 6'o55;
    localparam logic [5:0] OPC_BR   = 6'o46;
    localparam logic [5:0] OPC_BRI  = 6'o56;
    localparam logic [5:0] OPC_BCC  = 6'o47;
    localparam logic [5:0] OPC_BCCI = 6'o57;
    localparam logic [5:0] OPC_MUL  = 6'o20;
    localparam logic [5:0] OPC_MULI = 6'o30;
    localparam logic [5:0] OPC_BSF  = 6'o21;
    localparam logic [5:0] OPC_BSFI = 6'o31;

    // An interrupt must not split an IMM prefix from its user, nor land in a delay slot.
    function automatic logic isIntBlocked(input logic [5:0] opc);
        return (opc == OPC_IMM) || (opc == OPC_RTD) || (opc == OPC_BR) ||
               (opc == OPC_BRI) || (opc == OPC_BCC) || (opc == OPC_BCCI);
    endfunction

    function automatic logic isMulBsf(input logic [5:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_MULI) ||
               (opc == OPC_BSF) || (opc == OPC_BSFI);
    endfunction

    // Takes the class bits {opc[5:4], opc[2]}: 3'o6 are loads, 3'o7 are stores.
    function automatic logic isLdSt(input logic [2:0] cls);
        return (cls == 3'o6) || (cls == 3'o7);
    endfunction

    function automatic bit depthValid(input int d);
        return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
    endfunction

    function automatic bit nintValid(input int n);
        return (n >= 1) && (n <= 8);
    endfunction

endpackage

// File: rtl/aexm_iqueue_fifo.sv
// Instruction prefetch storage: circular buffer with pointers, occupancy,
// flush, and push-while-full when a pop frees a slot in the same cycle.
module aexm_iqueue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     gclk,
    input  logic                     grst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              wdata,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;
    logic          doPush;
    logic          doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty & ~flush;
    assign doPush = push & (~full | doPop) & ~flush;
    assign head   = mem[rdPtr];

    // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
    always_ff @(posedge gclk) begin
        if (grst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge gclk) begin
        if (!grst && doPush) mem[wrPtr] <= wdata;
    end

endmodule

// File: rtl/aexm_iqueue.sv
// AEXM instruction queue: prefetch FIFO, interrupt injection, IMM fusing
// and MUL/BSF stall. Define AEXM_IQUEUE_LDST_STALL_EN to stall loads/stores too.
module aexm_iqueue
    import aexm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NINT  = 4
) (
    input  logic                                     gclk,
    input  logic                                     grst,
    input  logic                                     gena,
    input  logic                                     oena,
    input  logic                                     rBRA,
    input  logic                                     rMSR_IE,
    input  logic                                     icache_valid,
    input  logic [31:0]                              icache_datai,
    output logic                                     icache_enable,
    input  logic [NINT-1:0]                          sys_int_i,
    output logic [31:0]                              xIREG,
    output logic [31:0]                              rIREG,
    output logic [31:0]                              rSIMM,
    output logic                                     rVALID,
    output logic [((NINT > 1) ? $clog2(NINT) : 1)-1:0] rINTID,
    output logic                                     rSTALL,
    output logic [$clog2(DEPTH):0]                   count
);
    localparam int IW = (NINT > 1) ? $clog2(NINT) : 1;

    if (!depthValid(DEPTH)) begin : gBadDepth
        $error("aexm_iqueue: DEPTH must be a power of two in 2..16");
    end
    if (!nintValid(NINT)) begin : gBadNint
        $error("aexm_iqueue: NINT must be in 1..8");
    end

    logic [31:0]     head;
    logic            full;
    logic            empty;
    logic            inject;
    logic            stallOpc;
    logic [5:0]      xOpc;
    logic [NINT-1:0] syncA;
    logic [NINT-1:0] syncB;
    logic [NINT-1:0] pending;
    logic [NINT-1:0] intHot;
    logic [NINT-1:0] intClr;
    logic [IW-1:0]   intSel;

    aexm_iqueue_fifo #(.DEPTH(DEPTH)) uFifo (
        .gclk  (gclk),
        .grst  (grst),
        .flush (rBRA),
        .push  (icache_valid),
        .pop   (gena & ~inject),
        .wdata (icache_datai),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign icache_enable = ~full;

    // Lowest-index pending line wins.
    always_comb begin
        intSel = '0;
        intHot = '0;
        for (int i = NINT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                intSel    = IW'(i);
                intHot    = '0;
                intHot[i] = 1'b1;
            end
        end
    end

    assign inject = rMSR_IE & (|pending) & ~isIntBlocked(rIREG[31:26]) & ~rBRA;
    assign intClr = (inject & gena) ? intHot : '0;

    always_comb begin
        if (rBRA)        xIREG = NOP_WORD;
        else if (inject) xIREG = INT_WORD;
        else if (!empty) xIREG = head;
        else             xIREG = NOP_WORD;
    end

    assign xOpc = xIREG[31:26];

`ifdef AEXM_IQUEUE_LDST_STALL_EN
    assign stallOpc = isMulBsf(xOpc) | isLdSt({xOpc[5:4], xOpc[2]});
`else
    assign stallOpc = isMulBsf(xOpc);
`endif

    always_ff @(posedge gclk) begin
        if (grst) begin
            rIREG  <= '0;
            rSIMM  <= '0;
            rVALID <= 1'b0;
            rINTID <= '0;
        end else if (gena) begin
            rIREG  <= xIREG;
            rSIMM  <= (rIREG[31:26] == OPC_IMM && !rBRA) ? {rIREG[15:0], xIREG[15:0]}
                                                         : {{16{xIREG[15]}}, xIREG[15:0]};
            rVALID <= inject | (~rBRA & ~empty);
            if (inject) rINTID <= intSel;
        end
    end

    always_ff @(posedge gclk) begin
        if (grst)        rSTALL <= 1'b0;
        else if (rSTALL) rSTALL <= oena;
        else             rSTALL <= stallOpc;
    end

    // Interrupt lines are only observed while globally enabled.
    always_ff @(posedge gclk) begin
        if (grst || !rMSR_IE) begin
            syncA   <= '0;
            syncB   <= '0;
            pending <= '0;
        end else begin
            syncA   <= sys_int_i;
            syncB   <= syncA;
            pending <= (pending & ~intClr) | syncB;
        end
    end

endmodule

// File: tb/tb_aexm_iqueue.sv
// Self-checking bench for aexm_iqueue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_aexm_iqueue;

    localparam int DEPTH = 4;
    localparam int NINT  = 4;
    localparam logic [31:0] NOP = 32'h88000000;
    localparam logic [31:0] INTW = 32'hB9CE0010;

    logic        gclk = 1'b0;
    logic        grst, gena, oena, rBRA, rMSR_IE, icache_valid;
    logic [31:0] icache_datai;
    logic        icache_enable;
    logic [3:0]  sys_int_i;
    logic [31:0] xIREG, rIREG, rSIMM;
    logic        rVALID;
    logic [1:0]  rINTID;
    logic        rSTALL;
    logic [2:0]  count;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state
    logic [31:0] mQ[$];
    logic [31:0] mIreg, mSimm;
    logic        mValid, mStall;
    logic [1:0]  mIntid;
    logic [3:0]  mPend, mSyncA, mSyncB;
    logic [31:0] expX;
    logic        expInj;
    logic [1:0]  expSel;

    aexm_iqueue #(.DEPTH(DEPTH), .NINT(NINT)) dut (
        .gclk          (gclk),
        .grst          (grst),
        .gena          (gena),
        .oena          (oena),
        .rBRA          (rBRA),
        .rMSR_IE       (rMSR_IE),
        .icache_valid  (icache_valid),
        .icache_datai  (icache_datai),
        .icache_enable (icache_enable),
        .sys_int_i     (sys_int_i),
        .xIREG         (xIREG),
        .rIREG         (rIREG),
        .rSIMM         (rSIMM),
        .rVALID        (rVALID),
        .rINTID        (rINTID),
        .rSTALL        (rSTALL),
        .count         (count)
    );

    always #5 gclk = ~gclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic blockedOpc(input logic [5:0] opc);
        case (opc)
            6'o54, 6'o55, 6'o46, 6'o56, 6'o47, 6'o57: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic stallOp(input logic [5:0] opc);
        logic [2:0] cls;
        cls = {opc[5:4], opc[2]};
        case (opc)
            6'o20, 6'o30, 6'o21, 6'o31: return 1'b1;
            default: ;
        endcase
`ifdef AEXM_IQUEUE_LDST_STALL_EN
        if (cls == 3'o6 || cls == 3'o7) return 1'b1;
`endif
        return (cls == 3'b111) && 1'b0;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mIreg = '0; mSimm = '0; mValid = 1'b0; mStall = 1'b0; mIntid = '0;
        mPend = '0; mSyncA = '0; mSyncB = '0;
    endtask

    task automatic modelComb();
        expInj = rMSR_IE && (mPend != 0) && !blockedOpc(mIreg[31:26]) && !rBRA;
        expSel = '0;
        for (int i = 3; i >= 0; i--) if (mPend[i]) expSel = 2'(i);
        if (rBRA)              expX = NOP;
        else if (expInj)       expX = INTW;
        else if (mQ.size() > 0) expX = mQ[0];
        else                   expX = NOP;
    endtask

    task automatic modelStep();
        int   sz;
        logic popNow, pushNow;
        sz = mQ.size();
        if (grst) begin
            modelReset();
            return;
        end
        popNow  = gena && !rBRA && !expInj && sz > 0;
        pushNow = icache_valid && !rBRA && (sz < DEPTH || popNow);
        if (gena) begin
            mSimm  = (mIreg[31:26] == 6'o54 && !rBRA) ? {mIreg[15:0], expX[15:0]}
                                                      : {{16{expX[15]}}, expX[15:0]};
            mValid = expInj || (!rBRA && sz > 0);
            if (expInj) mIntid = expSel;
            mIreg  = expX;
        end
        mStall = mStall ? oena : stallOp(expX[31:26]);
        if (rBRA) mQ.delete();
        else begin
            if (popNow)  void'(mQ.pop_front());
            if (pushNow) mQ.push_back(icache_datai);
        end
        if (!rMSR_IE) begin
            mPend = '0; mSyncA = '0; mSyncB = '0;
        end else begin
            mPend  = (mPend & ~((expInj && gena) ? (4'b0001 << expSel) : 4'b0000)) | mSyncB;
            mSyncB = mSyncA;
            mSyncA = sys_int_i;
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then registered ones.
    task automatic applyStimulus(input logic rst, input logic ena, input logic oe, input logic bra,
                                 input logic ie, input logic valid, input logic [31:0] data,
                                 input logic [3:0] irq);
        @(negedge gclk);
        grst = rst; gena = ena; oena = oe; rBRA = bra; rMSR_IE = ie;
        icache_valid = valid; icache_datai = data; sys_int_i = irq;
        #1;
        modelComb();
        checkOutput("xIREG", xIREG, expX);
        checkOutput("icache_enable", 32'(icache_enable), 32'(mQ.size() < DEPTH));
        @(posedge gclk);
        modelStep();
        #1;
        checkOutput("rIREG", rIREG, mIreg);
        checkOutput("rSIMM", rSIMM, mSimm);
        checkOutput("rVALID", 32'(rVALID), 32'(mValid));
        checkOutput("rINTID", 32'(rINTID), 32'(mIntid));
        checkOutput("rSTALL", 32'(rSTALL), 32'(mStall));
        checkOutput("count", 32'(count), 32'(mQ.size()));
    endtask

    task automatic idle(input logic ena, input logic ie, input logic oe);
        applyStimulus(1'b0, ena, oe, 1'b0, ie, 1'b0, 32'h0, 4'h0);
    endtask

    logic [5:0] opcPick [5] = '{6'o54, 6'o20, 6'o60, 6'o46, 6'o56};

    initial begin
        logic [31:0] data;
        logic        ena, bra, rst;
        logic [3:0]  irq;

        grst = 1'b1; gena = 1'b0; oena = 1'b0; rBRA = 1'b0; rMSR_IE = 1'b0;
        icache_valid = 1'b0; icache_datai = '0; sys_int_i = '0;
        repeat (2) @(posedge gclk);
        #1;
        modelReset();
        checkOutput("resetIreg", rIREG, 32'h0);
        checkOutput("resetSimm", rSIMM, 32'h0);
        checkOutput("resetValid", 32'(rVALID), 32'h0);
        checkOutput("resetStall", 32'(rSTALL), 32'h0);
        checkOutput("resetCount", 32'(count), 32'h0);
        checkOutput("resetEnable", 32'(icache_enable), 32'h1);

        // Fill past capacity, then drain in order
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000_0000 + 32'(i), 4'h0);
        checkOutput("fullCount", 32'(count), 32'd4);
        checkOutput("fullEnable", 32'(icache_enable), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b0, 1'b0);
            checkOutput("fifoOrder", rIREG, 32'h3000_0000 + 32'(i));
        end

        // Empty queue starvation
        idle(1'b1, 1'b0, 1'b0);
        checkOutput("starveValid", 32'(rVALID), 32'h0);
        checkOutput("starveIreg", rIREG, NOP);

        // Branch flush discards a same-cycle push
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3400_0000 + 32'(i), 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3400_00FF, 4'h0);
        checkOutput("flushCount", 32'(count), 32'h0);

        // IMM fusing with an interrupt deferred past the fused pair
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_1234, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3060_5678, 4'h0);
        idle(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0001);
        repeat (3) idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        checkOutput("immFuse", rSIMM, 32'h1234_5678);
        checkOutput("immUser", rIREG, 32'h3060_5678);
        idle(1'b1, 1'b1, 1'b0);
        checkOutput("deferredInt", rIREG, INTW);

        // Two pending lines served lowest first
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1010);
        repeat (3) idle(1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        checkOutput("intFirst", rIREG, INTW);
        checkOutput("intIdFirst", 32'(rINTID), 32'd1);
        idle(1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        checkOutput("intIdSecond", 32'(rINTID), 32'd3);
        checkOutput("intNoPop", 32'(count), 32'd0);

        // MUL stall, then a load
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 4'h0);
        idle(1'b0, 1'b0, 1'b1);
        checkOutput("mulStallRise", 32'(rSTALL), 32'h1);
        idle(1'b0, 1'b0, 1'b1);
        checkOutput("mulStallHold", 32'(rSTALL), 32'h1);
        idle(1'b0, 1'b0, 1'b0);
        checkOutput("mulStallFall", 32'(rSTALL), 32'h0);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0000, 4'h0);
        idle(1'b0, 1'b0, 1'b0);
`ifdef AEXM_IQUEUE_LDST_STALL_EN
        checkOutput("loadStall", 32'(rSTALL), 32'h1);
`else
        checkOutput("loadStall", 32'(rSTALL), 32'h0);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            data = $urandom;
            if ($urandom_range(0, 3) == 0) data[31:26] = opcPick[$urandom_range(0, 4)];
            rst = ($urandom_range(0, 79) == 0);
            bra = ($urandom_range(0, 9) == 0);
            ena = ($urandom_range(0, 3) != 0);
            irq = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            applyStimulus(rst, ena, 1'($urandom_range(0, 1)), bra,
                          ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), data, irq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
